mod_n_time_counter: RTL and testbench

//  Parametrised modulo-N time-field counter; one instance serves seconds, minutes, hours, day or month.

---
 rtl/mod_n_time_counter_if.sv | 27 ++
 rtl/mod_n_time_counter.sv | 64 ++++++
 tb/tb_mod_n_time_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mod_n_time_counter_if.sv
// mod_n_time_counter_if: control, load, alarm and status bundle of one time-field counter
// master drives i_* (tick, enables, load bus, alarm setup); slave is the counter, driving o_*
interface mod_n_time_counter_if #(parameter int WIDTH = 6, parameter int ADDR_W = 2);
  logic              i_tick_in;
  logic              i_count_en;
  logic              i_up_down;
  logic              i_load;
  logic [ADDR_W-1:0] i_addrs;
  logic [WIDTH-1:0]  i_data_in;
  logic [WIDTH-1:0]  i_alarm_val;
  logic              i_alarm_en;
  logic              i_alarm_clr;
  logic [WIDTH-1:0]  o_q;
  logic              o_carry_out;
  logic [3:0]        o_q_tens;
  logic [3:0]        o_q_units;
  logic              o_load_err;
  logic              o_alarm_flag;
  modport master (
    output i_tick_in, i_count_en, i_up_down, i_load, i_addrs, i_data_in, i_alarm_val, i_alarm_en, i_alarm_clr,
    input  o_q, o_carry_out, o_q_tens, o_q_units, o_load_err, o_alarm_flag
  );
  modport slave (
    input  i_tick_in, i_count_en, i_up_down, i_load, i_addrs, i_data_in, i_alarm_val, i_alarm_en, i_alarm_clr,
    output o_q, o_carry_out, o_q_tens, o_q_units, o_load_err, o_alarm_flag
  );
endinterface

// File: rtl/mod_n_time_counter.sv
// mod_n_time_counter: chainable modulo-N up/down time-field counter with addressed load, alarm and BCD output
// clk, reset (sync, active-high); bus: slave side of mod_n_time_counter_if
//   o_q count, o_carry_out combinational wrap (feeds next stage i_tick_in), o_q_tens/o_q_units BCD of o_q
//   one cycle late, o_load_err one-cycle rejected-load pulse, o_alarm_flag sticky alarm match
module mod_n_time_counter #(
  parameter int WIDTH     = 6,
  parameter int MODULUS   = 60,
  parameter int MIN_VALUE = 0,
  parameter int ADDR_W    = 2,
  parameter int MY_ADDR   = 1
) (
  input logic clk,
  input logic reset,
  mod_n_time_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MIN_VALUE + MODULUS - 1);
  localparam logic [WIDTH-1:0] SPAN = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_q;
  logic [3:0]       r_q_tens;
  logic [3:0]       r_q_units;
  logic             r_load_err;
  logic             r_alarm_flag;
  logic             w_hit;
  logic             w_tick;
  logic             w_data_ok;
  logic             w_q_ok;
  logic             w_set;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;
  logic [WIDTH-1:0] w_q_next;
  // offset-from-minimum compare: values below MINV wrap to large numbers and fall out of range
  assign w_data_ok = (bus.i_data_in - MINV) <= SPAN;
  assign w_q_ok    = (r_q - MINV) <= SPAN;
  assign w_hit     = bus.i_load & (bus.i_addrs == ADDR_W'(MY_ADDR));
  assign w_tick    = bus.i_tick_in & bus.i_count_en & ~w_hit;
  assign w_up_next = (!w_q_ok || r_q == MAXV) ? MINV : r_q + 1'b1;
  assign w_dn_next = (!w_q_ok || r_q == MINV) ? MAXV : r_q - 1'b1;
  assign w_q_next  = w_hit ? (w_data_ok ? bus.i_data_in : r_q) :
                     w_tick ? (bus.i_up_down ? w_up_next : w_dn_next) : r_q;
  assign w_set     = bus.i_alarm_en & (w_q_next == bus.i_alarm_val) & (w_q_next != r_q);
  // an out-of-range q wraps without a carry; reset masks the carry so a chain never advances under reset
  assign bus.o_carry_out = ~reset & w_tick & w_q_ok & (bus.i_up_down ? r_q == MAXV : r_q == MINV);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= MINV;
      r_q_tens     <= 4'(MIN_VALUE / 10);
      r_q_units    <= 4'(MIN_VALUE % 10);
      r_load_err   <= 1'b0;
      r_alarm_flag <= 1'b0;
    end else begin
      r_q          <= w_q_next;
      r_q_tens     <= 4'(r_q / WIDTH'(10));
      r_q_units    <= 4'(r_q % WIDTH'(10));
      r_load_err   <= w_hit & ~w_data_ok;
      r_alarm_flag <= w_set | (r_alarm_flag & ~bus.i_alarm_clr);
    end
  end
  assign bus.o_q          = r_q;
  assign bus.o_q_tens     = r_q_tens;
  assign bus.o_q_units    = r_q_units;
  assign bus.o_load_err   = r_load_err;
  assign bus.o_alarm_flag = r_alarm_flag;
endmodule

// File: tb/tb_mod_n_time_counter.sv
// tb_mod_n_time_counter: directed checks of a 60x60 chained pair and a 1..12 field
module tb_mod_n_time_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mod_n_time_counter_if #(.WIDTH(6), .ADDR_W(2)) b0 ();
  mod_n_time_counter_if #(.WIDTH(6), .ADDR_W(2)) b1 ();
  mod_n_time_counter_if #(.WIDTH(4), .ADDR_W(2)) b2 ();
  mod_n_time_counter #(.WIDTH(6), .MODULUS(60), .MIN_VALUE(0), .ADDR_W(2), .MY_ADDR(1)) u_sec (.clk(clk), .reset(reset), .bus(b0));
  mod_n_time_counter #(.WIDTH(6), .MODULUS(60), .MIN_VALUE(0), .ADDR_W(2), .MY_ADDR(2)) u_min (.clk(clk), .reset(reset), .bus(b1));
  mod_n_time_counter #(.WIDTH(4), .MODULUS(12), .MIN_VALUE(1), .ADDR_W(2), .MY_ADDR(3)) u_mon (.clk(clk), .reset(reset), .bus(b2));
  assign b1.i_tick_in = b0.o_carry_out;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    {b0.i_tick_in, b0.i_count_en, b0.i_up_down, b0.i_load, b0.i_alarm_en, b0.i_alarm_clr} = '0;
    b0.i_addrs = '0; b0.i_data_in = '0; b0.i_alarm_val = '0;
    {b1.i_count_en, b1.i_up_down, b1.i_load, b1.i_alarm_en, b1.i_alarm_clr} = 5'b11000;
    b1.i_addrs = '0; b1.i_data_in = '0; b1.i_alarm_val = '0;
    {b2.i_tick_in, b2.i_count_en, b2.i_up_down, b2.i_load, b2.i_alarm_en, b2.i_alarm_clr} = '0;
    b2.i_addrs = '0; b2.i_data_in = '0; b2.i_alarm_val = '0;
    step(2);
    // reset state; a down tick at q=MIN would carry if reset did not mask it
    b0.i_tick_in = 1; b0.i_count_en = 1; b0.i_up_down = 0;
    #1;
    chk("rst_carry", b0.o_carry_out, 0);
    step();
    chk("rst_q", b0.o_q, 0);
    chk("rst_bcd", {b0.o_q_tens, b0.o_q_units}, 8'h00);
    chk("rst_lerr", b0.o_load_err, 0);
    chk("rst_flag", b0.o_alarm_flag, 0);
    chk("rst_q_mon", b2.o_q, 1);
    chk("rst_bcd_mon", {b2.o_q_tens, b2.o_q_units}, 8'h01);
    b0.i_tick_in = 0; reset = 0;
    // 1: up wrap at 59
    b0.i_load = 1; b0.i_addrs = 1; b0.i_data_in = 58;
    step();
    b0.i_load = 0;
    chk("ld58", b0.o_q, 58);
    b0.i_up_down = 1; b0.i_tick_in = 1;
    #1;
    chk("carry58", b0.o_carry_out, 0);
    step();
    chk("q59", b0.o_q, 59);
    chk("carry59", b0.o_carry_out, 1);
    chk("bcd58", {b0.o_q_tens, b0.o_q_units}, 8'h58);
    step();
    chk("q0", b0.o_q, 0);
    chk("bcd59", {b0.o_q_tens, b0.o_q_units}, 8'h59);
    chk("carry0_up", b0.o_carry_out, 0);
    step();
    chk("q1", b0.o_q, 1);
    // 2: down wrap
    b0.i_up_down = 0;
    step();
    chk("dn_q0", b0.o_q, 0);
    chk("dn_carry0", b0.o_carry_out, 1);
    step();
    chk("dn_q59", b0.o_q, 59);
    b0.i_tick_in = 0;
    b2.i_tick_in = 1; b2.i_count_en = 1; b2.i_up_down = 0;
    #1;
    chk("mon_carry", b2.o_carry_out, 1);
    step();
    b2.i_tick_in = 0;
    chk("mon_q12", b2.o_q, 12);
    // 3: rejected load, foreign-address load
    b0.i_load = 1; b0.i_addrs = 1; b0.i_data_in = 60;
    step();
    chk("bad_ld_q", b0.o_q, 59);
    chk("bad_ld_err", b0.o_load_err, 1);
    b0.i_load = 0;
    step();
    chk("err_pulse", b0.o_load_err, 0);
    b0.i_load = 1; b0.i_addrs = 2; b0.i_data_in = 10; b0.i_tick_in = 1; b0.i_up_down = 1;
    #1;
    chk("foreign_carry", b0.o_carry_out, 1);
    step();
    chk("foreign_q", b0.o_q, 0);
    chk("foreign_err", b0.o_load_err, 0);
    // 4: load beats tick; count_en gates tick
    b0.i_addrs = 1; b0.i_data_in = 59; b0.i_up_down = 0;
    #1;
    chk("hit_carry", b0.o_carry_out, 0);
    step();
    chk("hit_q", b0.o_q, 59);
    b0.i_load = 0; b0.i_up_down = 1; b0.i_count_en = 0;
    #1;
    chk("hold_carry", b0.o_carry_out, 0);
    step();
    chk("hold_q", b0.o_q, 59);
    b0.i_tick_in = 0; b0.i_count_en = 1;
    // 5: alarm
    b0.i_load = 1; b0.i_data_in = 29; b0.i_alarm_val = 30; b0.i_alarm_en = 1;
    step();
    b0.i_load = 0;
    chk("al_q29", b0.o_q, 29);
    chk("al_flag29", b0.o_alarm_flag, 0);
    b0.i_tick_in = 1; b0.i_alarm_clr = 1;
    step();
    b0.i_tick_in = 0;
    chk("al_q30", b0.o_q, 30);
    chk("al_set_wins", b0.o_alarm_flag, 1);
    step();
    chk("al_clr", b0.o_alarm_flag, 0);
    b0.i_alarm_clr = 0;
    step(2);
    chk("al_hold", b0.o_alarm_flag, 0);
    chk("al_hold_q", b0.o_q, 30);
    // 6: 60x60 chain
    reset = 1;
    step();
    reset = 0;
    b0.i_tick_in = 1;
    step(3599);
    chk("ch_sec59", b0.o_q, 59);
    chk("ch_min59", b1.o_q, 59);
    chk("ch_c0", b0.o_carry_out, 1);
    chk("ch_c1", b1.o_carry_out, 1);
    step();
    chk("ch_wrap", {b1.o_q, b0.o_q}, 0);
    step(100);
    chk("ch_sec40", b0.o_q, 40);
    chk("ch_min1", b1.o_q, 1);
    chk("ch_flag", b0.o_alarm_flag, 1);
    reset = 1;
    b1.i_load = 1; b1.i_addrs = 2; b1.i_data_in = 5;
    #1;
    chk("mid_rst_carry", b0.o_carry_out, 0);
    step();
    chk("mid_rst_q", {b1.o_q, b0.o_q}, 0);
    chk("mid_rst_flag", b0.o_alarm_flag, 0);
    step();
    chk("mid_rst_bcd", {b0.o_q_tens, b0.o_q_units}, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
